lcd_text_buf: RTL and testbench

LCD_TEXT_BUF -- requirements
Module: lcd_text_buf

---
 rtl/lcd_text_buf_if.sv | 34 +++
 rtl/lcd_text_buf.sv | 115 +++++++++++
 tb/tb_lcd_text_buf.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_buf_if.sv
// Host-write / driver-read bundle for the 32-cell LCD text buffer.
// wr_auto exists only when LCD_TEXT_BUF_AUTOINC_EN is defined.
interface lcd_text_buf_if;
`ifdef LCD_TEXT_BUF_AUTOINC_EN
  logic       wr_auto;
`endif
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr;
  logic       busy;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       upd_req;
  logic       upd_ack;

  modport master (
`ifdef LCD_TEXT_BUF_AUTOINC_EN
    output wr_auto,
`endif
    output wr_en, wr_addr, wr_data, clr,
    output rd_addr, upd_ack,
    input  busy, rd_data, upd_req
  );

  modport slave (
`ifdef LCD_TEXT_BUF_AUTOINC_EN
    input  wr_auto,
`endif
    input  wr_en, wr_addr, wr_data, clr,
    input  rd_addr, upd_ack,
    output busy, rd_data, upd_req
  );
endinterface

// File: rtl/lcd_text_buf.sv
// 2x16 LCD character store with clear sequencer and refresh request flag.
// Optional write cursor: define LCD_TEXT_BUF_AUTOINC_EN.
module lcd_text_buf #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic           lcdclk,
  input  logic           resetn,
  lcd_text_buf_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       upd_req_q, upd_req_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] mem_q [32];

  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic       host_wr;
  logic       clr_done;
  logic [4:0] wr_sel;

`ifdef LCD_TEXT_BUF_AUTOINC_EN
  logic [4:0] cursor_q, cursor_d;

  always_comb begin
    wr_sel = bus.wr_auto ? cursor_q : bus.wr_addr;
  end

  // Any clear activity parks the cursor at cell 0.
  always_comb begin
    cursor_d = cursor_q;
    if (state_q == CLEAR || bus.clr) begin
      cursor_d = '0;
    end else if (host_wr) begin
      cursor_d = wr_sel + 5'd1;
    end
  end

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) cursor_q <= '0;
    else         cursor_q <= cursor_d;
  end
`else
  always_comb begin
    wr_sel = bus.wr_addr;
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we       = 1'b0;
    waddr    = wr_sel;
    wdata    = bus.wr_data;
    host_wr  = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (bus.wr_en) begin
          host_wr = 1'b1;
          we      = 1'b1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = idx_q;
        wdata = FILL_CHAR;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d  = IDLE;
          clr_done = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // A new change always beats a same-cycle acknowledge.
  always_comb begin
    upd_req_d = host_wr | clr_done
              | (upd_req_q & ~bus.upd_ack);
    rd_data_d = mem_q[bus.rd_addr];
  end

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      upd_req_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      upd_req_q <= upd_req_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Contents are defined by the post-reset clear, so no reset here.
  always_ff @(posedge lcdclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.busy    = (state_q == CLEAR);
  assign bus.rd_data = rd_data_q;
  assign bus.upd_req = upd_req_q;

endmodule

// File: tb/tb_lcd_text_buf.sv
// Directed bench for lcd_text_buf: vector table plus clear/reset sequences.
// Autoinc cases compile only with LCD_TEXT_BUF_AUTOINC_EN.
module tb_lcd_text_buf;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lcd_text_buf_if bus ();

  lcd_text_buf #(.FILL_CHAR(8'h20)) dut (
    .lcdclk (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic       ack;
    logic [4:0] rd_addr;
    logic       e_busy;
    logic       e_upd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.clr     = 1'b0;
    bus.upd_ack = 1'b0;
`ifdef LCD_TEXT_BUF_AUTOINC_EN
    bus.wr_auto = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    int cnt;
    resetn = 1'b0;
    #2;
    chk({tag, "_rst_rd"}, 32'(bus.rd_data), 32'h00);
    chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_rst_upd"}, 32'(bus.upd_req), 32'd0);
    tick();
    chk({tag, "_rst_hold_busy"}, 32'(bus.busy), 32'd1);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.busy && cnt < 40);
    chk({tag, "_clear_cycles"}, 32'(cnt), 32'd32);
    chk({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_post_upd"}, 32'(bus.upd_req), 32'd1);
  endtask

  task automatic read_chk(input string nm,
                          input logic [4:0] a,
                          input logic [7:0] e);
    bus.rd_addr = a;
    tick();
    chk(nm, 32'(bus.rd_data), 32'(e));
  endtask

  initial begin
    int cnt;
    vt[0] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 8'h20};
    vt[1] = '{1'b1, 5'd5,  8'h41, 1'b0, 1'b0, 5'd5,  1'b0, 1'b1, 8'h20};
    vt[2] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd5,  1'b0, 1'b1, 8'h41};
    vt[3] = '{1'b1, 5'd6,  8'h42, 1'b0, 1'b1, 5'd6,  1'b0, 1'b1, 8'h20};
    vt[4] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 8'h42};
    vt[5] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 8'h20};
    vt[6] = '{1'b1, 5'd31, 8'h7E, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 8'h20};
    vt[7] = '{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 8'h7E};
    vt[8] = '{1'b1, 5'd3,  8'h5A, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 8'h20};

    idle_inputs();
    bus.rd_addr = '0;
    #1;
    do_reset("init");

    for (int i = 0; i < 32; i++) begin
      read_chk($sformatf("init_rd%0d", i), 5'(i), 8'h20);
    end

    for (int i = 0; i < 9; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_addr = vt[i].wr_addr;
      bus.wr_data = vt[i].wr_data;
      bus.clr     = vt[i].clr;
      bus.upd_ack = vt[i].ack;
      bus.rd_addr = vt[i].rd_addr;
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_upd", i), 32'(bus.upd_req), 32'(vt[i].e_upd));
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd_data), 32'(vt[i].e_rd));
    end

    // Clear started by vec8; poke it with writes/clr while busy.
    idle_inputs();
    bus.rd_addr = 5'd31;
    cnt = 0;
    do begin
      if (cnt == 1) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 8'h31;
        bus.clr     = 1'b1;
      end else begin
        idle_inputs();
      end
      tick();
      cnt++;
      if (cnt == 1) chk("clr_rd_during", 32'(bus.rd_data), 32'h7E);
      if (cnt == 16) chk("clr_upd_mid", 32'(bus.upd_req), 32'd0);
    end while (bus.busy && cnt < 40);
    idle_inputs();
    chk("clr_cycles", 32'(cnt), 32'd32);
    chk("clr_done_upd", 32'(bus.upd_req), 32'd1);
    read_chk("clr_rd3", 5'd3, 8'h20);
    read_chk("clr_rd7", 5'd7, 8'h20);
    read_chk("clr_rd5", 5'd5, 8'h20);
    read_chk("clr_rd31", 5'd31, 8'h20);

`ifdef LCD_TEXT_BUF_AUTOINC_EN
    bus.wr_en   = 1'b1;
    bus.wr_auto = 1'b0;
    bus.wr_addr = 5'd30;
    bus.wr_data = 8'h61;
    tick();
    bus.wr_auto = 1'b1;
    bus.wr_addr = 5'd10;
    bus.wr_data = 8'h62;
    tick();
    bus.wr_data = 8'h63;
    tick();
    idle_inputs();
    read_chk("auto_rd30", 5'd30, 8'h61);
    read_chk("auto_rd31", 5'd31, 8'h62);
    read_chk("auto_rd0", 5'd0, 8'h63);
    read_chk("auto_rd10", 5'd10, 8'h20);
`endif

    // Reset in the middle of a clear, with a write pending.
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (5) tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 8'h55;
    do_reset("mid");
    read_chk("mid_rd9", 5'd9, 8'h20);
    read_chk("mid_rd0", 5'd0, 8'h20);

    bus.upd_ack = 1'b1;
    tick();
    bus.upd_ack = 1'b0;
    chk("final_ack_upd", 32'(bus.upd_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
